// File: rtl/reaction_session_controller.sv
// Multi-round reaction-time session sequencer: pseudo-random foreperiod, stimulus,
// ms-resolution reaction measurement, false-start handling, best/average statistics.
module reaction_session_controller #(
   parameter int unsigned CLKS_PER_MS      = 50,
   parameter int unsigned MIN_DELAY_MS     = 1000,
   parameter int unsigned DELAY_RANGE_LOG2 = 12,
   parameter int unsigned ROUNDS_LOG2      = 2,
   parameter int unsigned MAX_MS           = 9999,
   parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   btn_start,
   input  logic                   btn_user,
   output logic                   led_react,
   output logic                   busy,
   output logic                   false_start,
   output logic                   result_valid,
   output logic [13:0]            result_ms,
   output logic [13:0]            best_ms,
   output logic [13:0]            avg_ms,
   output logic [ROUNDS_LOG2-1:0] round_idx,
   output logic                   session_done
);

   localparam int unsigned PW = (CLKS_PER_MS > 2) ? $clog2(CLKS_PER_MS) : 1;
   localparam int unsigned DW = $clog2(MIN_DELAY_MS + (1 << DELAY_RANGE_LOG2) + 1);
   localparam int unsigned SW = 14 + ROUNDS_LOG2;
   localparam logic [15:0] RAND_MASK = 16'((32'd1 << DELAY_RANGE_LOG2) - 32'd1);
   localparam logic [PW-1:0] PRESC_TC = PW'(CLKS_PER_MS - 1);
   localparam logic [13:0] MAX_CNT = 14'(MAX_MS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_WAIT,
      S_REACT,
      S_RECORD,
      S_RESULT,
      S_FOUL,
      S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [15:0]            lfsr_q, lfsr_d;
   logic [PW-1:0]          presc_q, presc_d;
   logic [DW-1:0]          delay_q, delay_d;
   logic [13:0]            ms_cnt_q, ms_cnt_d;
   logic [13:0]            result_q, result_d;
   logic                   rvalid_q, rvalid_d;
   logic                   foul_q, foul_d;
   logic [13:0]            best_q, best_d;
   logic [13:0]            avg_q, avg_d;
   logic [SW-1:0]          sum_q, sum_d;
   logic [ROUNDS_LOG2-1:0] round_q, round_d;
   logic                   tick;

   // Galois LFSR, free-running in every state so the foreperiod depends on start timing
   always_comb begin
      lfsr_d = lfsr_q >> 1;
      if (lfsr_q[0]) lfsr_d = (lfsr_q >> 1) ^ 16'hB400;
   end

   assign tick = (presc_q == PRESC_TC);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         lfsr_q   <= LFSR_SEED;
         presc_q  <= '0;
         delay_q  <= '0;
         ms_cnt_q <= '0;
         result_q <= '0;
         rvalid_q <= 1'b0;
         foul_q   <= 1'b0;
         best_q   <= MAX_CNT;
         avg_q    <= '0;
         sum_q    <= '0;
         round_q  <= '0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         presc_q  <= presc_d;
         delay_q  <= delay_d;
         ms_cnt_q <= ms_cnt_d;
         result_q <= result_d;
         rvalid_q <= rvalid_d;
         foul_q   <= foul_d;
         best_q   <= best_d;
         avg_q    <= avg_d;
         sum_q    <= sum_d;
         round_q  <= round_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      presc_d  = '0;
      delay_d  = delay_q;
      ms_cnt_d = ms_cnt_q;
      result_d = result_q;
      rvalid_d = 1'b0;
      foul_d   = 1'b0;
      best_d   = best_q;
      avg_d    = avg_q;
      sum_d    = sum_q;
      round_d  = round_q;

      unique case (state_q)
         S_IDLE: begin
            if (btn_start) state_d = S_ARM;
         end
         S_ARM: begin
            delay_d  = DW'(MIN_DELAY_MS) + DW'(lfsr_q & RAND_MASK);
            ms_cnt_d = '0;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            if (btn_user) begin
               state_d = S_FOUL;
               foul_d  = 1'b1;
            end else if (tick) begin
               // a zero-length foreperiod also fires on the first tick
               if (delay_q <= DW'(1)) begin
                  delay_d  = '0;
                  ms_cnt_d = '0;
                  state_d  = S_REACT;
               end else begin
                  delay_d = delay_q - DW'(1);
               end
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
         S_REACT: begin
            if (btn_user) begin
               state_d = S_RECORD;
            end else if (tick) begin
               if (ms_cnt_q >= MAX_CNT - 14'd1) begin
                  ms_cnt_d = MAX_CNT;
                  state_d  = S_RECORD;
               end else begin
                  ms_cnt_d = ms_cnt_q + 14'd1;
               end
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
         S_RECORD: begin
            result_d = ms_cnt_q;
            rvalid_d = 1'b1;
            sum_d    = sum_q + SW'(ms_cnt_q);
            if (ms_cnt_q < best_q) best_d = ms_cnt_q;
            round_d  = round_q + 1'b1;
            if (round_q == '1) begin
               avg_d   = 14'(sum_d >> ROUNDS_LOG2);
               state_d = S_DONE;
            end else begin
               state_d = S_RESULT;
            end
         end
         S_RESULT: begin
            if (btn_start) state_d = S_ARM;
         end
         S_FOUL: begin
            if (btn_start) state_d = S_ARM;
         end
         S_DONE: begin
            if (btn_start) begin
               sum_d   = '0;
               best_d  = MAX_CNT;
               round_d = '0;
               avg_d   = '0;
               state_d = S_ARM;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign led_react    = (state_q == S_REACT);
   assign busy         = (state_q == S_ARM) || (state_q == S_WAIT) ||
                         (state_q == S_REACT) || (state_q == S_RECORD);
   assign session_done = (state_q == S_DONE);
   assign false_start  = foul_q;
   assign result_valid = rvalid_q;
   assign result_ms    = result_q;
   assign best_ms      = best_q;
   assign avg_ms       = avg_q;
   assign round_idx    = round_q;

endmodule

// File: tb/tb_reaction_session_controller.sv
// Directed self-checking bench: fixed-foreperiod unit for session behaviour,
// random-foreperiod unit for LFSR reset reproducibility.
module tb_reaction_session_controller;

   logic        clk;
   logic        rst0, bs0, bu0;
   logic        led0, busy0, fs0, rv0, done0;
   logic [13:0] res0, best0, avg0;
   logic [1:0]  rnd0;

   logic        rst1, bs1, bu1;
   logic        led1, busy1, fs1, rv1, done1;
   logic [13:0] res1, best1, avg1;
   logic [1:0]  rnd1;

   int vectors;
   int miscompares;
   int n;

   reaction_session_controller #(
      .CLKS_PER_MS(2), .MIN_DELAY_MS(5), .DELAY_RANGE_LOG2(0),
      .ROUNDS_LOG2(2), .MAX_MS(20), .LFSR_SEED(16'hACE1)
   ) dut0 (
      .clk(clk), .rst(rst0), .btn_start(bs0), .btn_user(bu0),
      .led_react(led0), .busy(busy0), .false_start(fs0), .result_valid(rv0),
      .result_ms(res0), .best_ms(best0), .avg_ms(avg0), .round_idx(rnd0),
      .session_done(done0)
   );

   reaction_session_controller #(
      .CLKS_PER_MS(2), .MIN_DELAY_MS(3), .DELAY_RANGE_LOG2(4),
      .ROUNDS_LOG2(2), .MAX_MS(20), .LFSR_SEED(16'hACE1)
   ) dut1 (
      .clk(clk), .rst(rst1), .btn_start(bs1), .btn_user(bu1),
      .led_react(led1), .busy(busy1), .false_start(fs1), .result_valid(rv1),
      .result_ms(res1), .best_ms(best1), .avg_ms(avg1), .round_idx(rnd1),
      .session_done(done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic start0();
      bs0 = 1'b1; step(); bs0 = 1'b0;
   endtask

   task automatic press0();
      bu0 = 1'b1; step(); bu0 = 1'b0;
   endtask

   // called in the ARM cycle; returns cycles from the btn_start cycle to led rise
   task automatic wait_led0(output int cyc);
      cyc = 1;
      while (!led0 && cyc < 200) begin step(); cyc++; end
   endtask

   task automatic wait_led1(output int cyc);
      cyc = 1;
      while (!led1 && cyc < 200) begin step(); cyc++; end
   endtask

   // press after 'cyc' cycles in REACT, then advance to the result cycle
   task automatic react0(input int cyc);
      repeat (cyc) step();
      press0();
      step();
   endtask

   initial begin
      int seen;
      vectors = 0; miscompares = 0;
      rst0 = 1'b1; bs0 = 1'b0; bu0 = 1'b0;
      rst1 = 1'b1; bs1 = 1'b0; bu1 = 1'b0;
      step(); step();

      check("rst_led", int'(led0), 0);
      check("rst_busy", int'(busy0), 0);
      check("rst_best", int'(best0), 20);
      check("rst_result", int'(res0), 0);
      check("rst_rvalid", int'(rv0), 0);
      check("rst_round", int'(rnd0), 0);
      check("rst_avg", int'(avg0), 0);
      check("rst_done", int'(done0), 0);
      check("rst_false", int'(fs0), 0);
      rst0 = 1'b0;

      // fixed foreperiod 5 ms at 2 clk/ms: ARM + 10 WAIT + entry
      start0();
      check("arm_busy", int'(busy0), 1);
      wait_led0(n);
      check("t1_led_delay", n, 12);
      repeat (7) step();
      bu0 = 1'b1; bs0 = 1'b1; step(); bu0 = 1'b0; bs0 = 1'b0;
      check("t1_rv_lat1", int'(rv0), 0);
      step();
      check("t1_rvalid", int'(rv0), 1);
      check("t1_result", int'(res0), 3);
      check("t1_best", int'(best0), 3);
      check("t1_round", int'(rnd0), 1);
      check("t1_led_off", int'(led0), 0);
      step();
      check("t1_rv_pulse", int'(rv0), 0);
      check("t1_result_busy", int'(busy0), 0);

      // false start during WAIT
      start0();
      repeat (3) step();
      press0();
      check("t2_false", int'(fs0), 1);
      check("t2_round", int'(rnd0), 1);
      seen = 0;
      step();
      check("t2_false_pulse", int'(fs0), 0);
      repeat (20) begin
         if (led0) seen = 1;
         step();
      end
      check("t2_no_led", seen, 0);
      check("t2_round_hold", int'(rnd0), 1);
      check("t2_best_hold", int'(best0), 3);

      // rerun round 2 (5 ms), then rounds 3 (2 ms) and 4 (10 ms)
      start0();
      wait_led0(n);
      check("t2_rerun_delay", n, 12);
      react0(11);
      check("r2_result", int'(res0), 5);
      check("r2_best", int'(best0), 3);
      check("r2_round", int'(rnd0), 2);
      start0();
      wait_led0(n);
      react0(5);
      check("r3_result", int'(res0), 2);
      check("r3_best", int'(best0), 2);
      check("r3_round", int'(rnd0), 3);
      check("r3_done", int'(done0), 0);
      start0();
      wait_led0(n);
      react0(21);
      check("r4_result", int'(res0), 10);
      check("r4_best", int'(best0), 2);
      check("r4_round", int'(rnd0), 0);
      check("r4_done", int'(done0), 1);
      check("r4_avg", int'(avg0), 5);
      check("r4_busy", int'(busy0), 0);

      // restart from DONE clears statistics
      start0();
      check("rs_best", int'(best0), 20);
      check("rs_round", int'(rnd0), 0);
      check("rs_avg", int'(avg0), 0);
      check("rs_done", int'(done0), 0);
      check("rs_busy_arm", int'(busy0), 1);
      check("rs_led_arm", int'(led0), 0);

      // timeout at MAX_MS=20: 20th tick on cycle 12+39, RECORD, then result
      wait_led0(n);
      check("t4_led_delay", n, 12);
      n = 0;
      while (!rv0 && n < 100) begin step(); n++; end
      check("t4_timeout_lat", n, 41);
      check("t4_result", int'(res0), 20);
      check("t4_led_off", int'(led0), 0);
      check("t4_round", int'(rnd0), 1);
      check("t4_best", int'(best0), 20);

      // user press on the WAIT expiry cycle wins -> FOUL
      start0();
      repeat (10) step();
      press0();
      check("t5_expiry_foul", int'(fs0), 1);
      check("t5_expiry_led", int'(led0), 0);
      // btn_start in REACT ignored; press on tick cycle does not count that tick
      start0();
      wait_led0(n);
      repeat (2) step();
      start0();
      check("t5_start_ignored", int'(led0), 1);
      react0(2);
      check("t5_tick_press", int'(res0), 2);
      check("t5_round", int'(rnd0), 2);
      check("t5_best", int'(best0), 2);

      // reset mid-REACT
      start0();
      wait_led0(n);
      repeat (4) step();
      rst0 = 1'b1;
      step();
      check("t6_led", int'(led0), 0);
      check("t6_rvalid", int'(rv0), 0);
      check("t6_best", int'(best0), 20);
      check("t6_round", int'(rnd0), 0);
      check("t6_busy", int'(busy0), 0);
      check("t6_result", int'(res0), 0);
      rst0 = 1'b0;
      step();
      check("t6_idle_rvalid", int'(rv0), 0);

      // random foreperiod: ARM sees LFSR after 4 steps = 16'h1C4E -> 3+14 = 17 ms -> 36
      rst1 = 1'b0;
      repeat (3) step();
      bs1 = 1'b1; step(); bs1 = 1'b0;
      wait_led1(n);
      check("t6_rand_delay_a", n, 36);
      repeat (3) step();
      rst1 = 1'b1;
      step();
      check("t6_rand_led_rst", int'(led1), 0);
      check("t6_rand_best_rst", int'(best1), 20);
      step();
      rst1 = 1'b0;
      repeat (3) step();
      bs1 = 1'b1; step(); bs1 = 1'b0;
      wait_led1(n);
      check("t6_rand_delay_b", n, 36);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/reaction_session_controller.md
Name: reaction_session_controller

Overview:
Sequences a multi-round reaction-time session on top of the ms-timing datapath. Per round: a pseudo-random foreperiod, the react stimulus, then the measured reaction time. False starts are detected and the round is repeated. Accumulates best and average times over 2^ROUNDS_LOG2 valid rounds and presents binary results to the downstream BCD/display stage.

Parameters:
CLKS_PER_MS, 50, clk cycles per 1 ms tick (prescaler terminal count + 1); legal values ≥ 2
MIN_DELAY_MS, 1000, fixed part of the foreperiod in ms
DELAY_RANGE_LOG2, 12, random part of the foreperiod = lfsr[DELAY_RANGE_LOG2-1:0] ms; 0 gives a fixed foreperiod
ROUNDS_LOG2, 2, session length = 2^ROUNDS_LOG2 valid rounds
MAX_MS, 9999, reaction count saturation / timeout value
LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
btn_start  in  1  single-cycle pulse, already synchronized and debounced
btn_user  in  1  single-cycle pulse, already synchronized and debounced
led_react  out  1  stimulus; high exactly while in REACT
busy  out  1  high in ARM, WAIT, REACT, RECORD
false_start  out  1  one-cycle pulse on entry to FOUL
result_valid  out  1  one-cycle pulse when result_ms updates
result_ms  out  14  last recorded reaction time in ms
best_ms  out  14  minimum over the session; MAX_MS until the first record
avg_ms  out  14  sum >> ROUNDS_LOG2; valid when session_done
round_idx  out  ROUNDS_LOG2  count of completed valid rounds (mod 2^ROUNDS_LOG2)
session_done  out  1  high while in DONE

Behaviour:
- Reset is synchronous, active-high, on clock clk. On rst:
  - state = IDLE; LFSR = LFSR_SEED.
  - All outputs 0, except best_ms = MAX_MS.
  - Internal sum, prescaler and counters = 0.
  - Reset mid-round aborts with no result pulse.
- LFSR: 16-bit Galois, mask 16'hB400. Advances every cycle, including IDLE.
- State machine (all registered; one transition per cycle at most):
  - IDLE: btn_start -> ARM.
  - ARM (1 cycle):
    - delay_ms = MIN_DELAY_MS + lfsr[DELAY_RANGE_LOG2-1:0].
    - prescaler = 0, ms_cnt = 0.
    - -> WAIT.
  - WAIT:
    - Prescaler counts 0..CLKS_PER_MS-1. At terminal count, delay_ms decrements.
    - When delay_ms reaches 0 on a tick -> REACT, with prescaler and ms_cnt cleared.
    - btn_user -> FOUL. btn_user has priority over a same-cycle expiry.
  - REACT:
    - led_react = 1. Prescaler runs; each tick increments ms_cnt.
    - btn_user -> RECORD, capturing ms_cnt. A tick in the same cycle as the press is not counted.
    - If ms_cnt reaches MAX_MS -> RECORD with MAX_MS (timeout, counted as a valid round).
  - RECORD (1 cycle):
    - result_ms = ms_cnt; result_valid pulse.
    - sum += ms_cnt. sum is 14+ROUNDS_LOG2 bits and cannot overflow.
    - best_ms = min(best_ms, ms_cnt).
    - round_idx increments.
    - If this was the final round -> DONE, else -> RESULT.
  - RESULT: btn_start -> ARM.
  - FOUL:
    - false_start pulses on entry. round_idx, sum and best are unchanged.
    - btn_start -> ARM to repeat the same round.
  - DONE:
    - session_done = 1; avg_ms = sum >> ROUNDS_LOG2 is registered on entry.
    - btn_start clears sum, best_ms (to MAX_MS), round_idx and avg_ms, then -> ARM.
- btn_start is ignored in ARM, WAIT, REACT and RECORD. btn_user is ignored in IDLE, ARM, RECORD, RESULT, FOUL and DONE.
- Result latency: result_ms and result_valid appear 2 cycles after the btn_user cycle in REACT.
- A reaction of k whole ms elapsed before the press yields result_ms = k.

Test Plan:
1. Fixed foreperiod (CLKS_PER_MS=2, MIN_DELAY_MS=5, DELAY_RANGE_LOG2=0): btn_start -> led_react rises after exactly 12 cycles (ARM + 10 WAIT + entry). btn_user 7 cycles later -> result_ms=3, result_valid pulse, best_ms=3, round_idx=1.
2. False start: btn_user during WAIT -> false_start pulse, led_react never rises, round_idx unchanged. btn_start -> round reruns and records normally.
3. Full session (ROUNDS_LOG2=2): reactions 3,5,2,10 ms -> best_ms=2, avg_ms=5 (20>>2), session_done=1. btn_start -> best_ms=MAX_MS, round_idx=0, state ARM.
4. Timeout (MAX_MS=20): no btn_user in REACT -> after 20 ticks result_ms=20, led_react low, round counted.
5. Simultaneous events: btn_user on the WAIT expiry cycle -> FOUL. btn_user on a REACT tick cycle -> tick not counted. btn_start during REACT -> ignored.
6. Reset mid-REACT: rst asserted -> next cycle led_react=0, result_valid=0, best_ms=MAX_MS, LFSR=LFSR_SEED, IDLE. A random-range run after reset reproduces the same foreperiod as the first run.
